// File: rtl/fft_bf_scheduler_if.sv
// rtl/fft_bf_scheduler_if.sv - control/address bundle between the FFT butterfly scheduler and RAM/butterfly datapath
interface fft_bf_scheduler_if #(
   parameter int N_LOG2 = 3
);
   logic              start;
   logic              busy;
   logic              done;
   logic [3:0]        stage;
   logic              rd_en;
   logic [N_LOG2-1:0] rd_addr_a;
   logic [N_LOG2-1:0] rd_addr_b;
   logic [N_LOG2-2:0] tw_addr;
   logic              wr_en;
   logic [N_LOG2-1:0] wr_addr_a;
   logic [N_LOG2-1:0] wr_addr_b;

   modport master (
      input  start,
      output busy, done, stage,
      output rd_en, rd_addr_a, rd_addr_b, tw_addr,
      output wr_en, wr_addr_a, wr_addr_b
   );

   modport slave (
      output start,
      input  busy, done, stage,
      input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
      input  wr_en, wr_addr_a, wr_addr_b
   );
endinterface

// File: rtl/fft_bf_scheduler.sv
// rtl/fft_bf_scheduler.sv - in-place radix-2 DIT FFT sequencer: read/twiddle/write-back addressing with per-stage pipeline drain
module fft_bf_scheduler #(
   parameter int N_LOG2     = 3,
   parameter int BF_LATENCY = 3,
   parameter int RD_LATENCY = 1
) (
   input logic                clk,
   input logic                reset,
   fft_bf_scheduler_if.master bus
);
   localparam int AW = N_LOG2;
   localparam int KW = N_LOG2 - 1;
   localparam int D  = RD_LATENCY + BF_LATENCY;
   localparam int CW = $clog2(D + 1);
   localparam logic [KW-1:0] K_LAST = KW'((1 << KW) - 1);
   localparam logic [3:0]    S_LAST = 4'(N_LOG2 - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

   state_e        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [3:0]    stage_q, stage_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          busy_q, done_q, rd_en_q;
   logic [AW-1:0] rd_a_q, rd_b_q;
   logic [KW-1:0] tw_q;

   logic [D-1:0]  wen_sr_q;
   logic [AW-1:0] wa_sr_q [D];
   logic [AW-1:0] wb_sr_q [D];

   function automatic logic [AW-1:0] addr_a_f(input logic [3:0] s, input logic [KW-1:0] k);
      logic [AW-1:0] kk, span, pos, grp;
      kk   = {1'b0, k};
      span = AW'(1) << s;
      pos  = kk & (span - AW'(1));
      grp  = kk >> s;
      return (grp << (s + 4'd1)) | pos;
   endfunction

   function automatic logic [KW-1:0] tw_f(input logic [3:0] s, input logic [KW-1:0] k);
      logic [AW-1:0] span, pos;
      span = AW'(1) << s;
      pos  = {1'b0, k} & (span - AW'(1));
      return KW'(pos << (4'(KW) - s));
   endfunction

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      stage_d = stage_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ISSUE;
               stage_d = 4'd0;
               k_d     = '0;
            end
         end
         ISSUE: begin
            if (k_q == K_LAST) begin
               state_d = DRAIN;
               cnt_d   = CW'(D);
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DRAIN: begin
            // D cycles here let the last write of this stage land before the next stage reads
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               if (stage_q == S_LAST) begin
                  state_d = DONE;
               end else begin
                  stage_d = stage_q + 4'd1;
                  k_d     = '0;
                  state_d = ISSUE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         k_q      <= '0;
         stage_q  <= 4'd0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rd_en_q  <= 1'b0;
         rd_a_q   <= '0;
         rd_b_q   <= '0;
         tw_q     <= '0;
         wen_sr_q <= '0;
         for (int i = 0; i < D; i++) begin
            wa_sr_q[i] <= '0;
            wb_sr_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
         // Outputs are registered from next-state so they line up with state_q
         busy_q  <= (state_d == ISSUE) || (state_d == DRAIN);
         done_q  <= (state_d == DONE);
         rd_en_q <= (state_d == ISSUE);
         if (state_d == ISSUE) begin
            rd_a_q <= addr_a_f(stage_d, k_d);
            rd_b_q <= addr_a_f(stage_d, k_d) + (AW'(1) << stage_d);
            tw_q   <= tw_f(stage_d, k_d);
         end
         wen_sr_q[0] <= rd_en_q;
         wa_sr_q[0]  <= rd_a_q;
         wb_sr_q[0]  <= rd_b_q;
         for (int i = 1; i < D; i++) begin
            wen_sr_q[i] <= wen_sr_q[i-1];
            wa_sr_q[i]  <= wa_sr_q[i-1];
            wb_sr_q[i]  <= wb_sr_q[i-1];
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.stage     = stage_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr_a = rd_a_q;
   assign bus.rd_addr_b = rd_b_q;
   assign bus.tw_addr   = tw_q;
   assign bus.wr_en     = wen_sr_q[D-1];
   assign bus.wr_addr_a = wa_sr_q[D-1];
   assign bus.wr_addr_b = wb_sr_q[D-1];
endmodule

// File: tb/tb_fft_bf_scheduler.sv
// tb/tb_fft_bf_scheduler.sv - directed bench for fft_bf_scheduler with a small RAM and butterfly model attached
module tb_fft_bf_scheduler;
   localparam int N_LOG2 = 3;
   localparam int N      = 8;
   localparam int D      = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fft_bf_scheduler_if #(.N_LOG2(N_LOG2)) sig ();

   fft_bf_scheduler #(
      .N_LOG2    (N_LOG2),
      .BF_LATENCY(3),
      .RD_LATENCY(1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (sig)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rd_cyc[$], rd_stg[$], rd_a[$], rd_b[$], rd_tw[$];
   int wr_cyc[$], wr_a[$], wr_b[$];
   int busy_cnt = 0, done_cnt = 0, done_cyc = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (sig.rd_en) begin
            rd_cyc.push_back(cyc);
            rd_stg.push_back(int'(sig.stage));
            rd_a.push_back(int'(sig.rd_addr_a));
            rd_b.push_back(int'(sig.rd_addr_b));
            rd_tw.push_back(int'(sig.tw_addr));
         end
         if (sig.wr_en) begin
            wr_cyc.push_back(cyc);
            wr_a.push_back(int'(sig.wr_addr_a));
            wr_b.push_back(int'(sig.wr_addr_b));
         end
         if (sig.busy) busy_cnt++;
         if (sig.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic clear_mon();
      rd_cyc.delete(); rd_stg.delete(); rd_a.delete(); rd_b.delete(); rd_tw.delete();
      wr_cyc.delete(); wr_a.delete(); wr_b.delete();
      busy_cnt = 0; done_cnt = 0; done_cyc = 0;
   endtask

   // Working RAM (1-cycle read) plus a 3-stage butterfly using the W0 twiddle
   logic signed [15:0] ram_re [N];
   logic signed [15:0] ram_im [N];
   logic               ram_load = 1'b0;
   logic signed [15:0] ar, ai, br, bi;
   logic [3:0][15:0]   p1, p2, p3;
   localparam logic signed [15:0] W_RE = 16'sh4000;
   localparam logic signed [15:0] W_IM = 16'sh0000;
   logic signed [31:0] m_re, m_im;

   always_comb begin
      m_re = (32'(br) * 32'(W_RE) - 32'(bi) * 32'(W_IM)) >>> 14;
      m_im = (32'(br) * 32'(W_IM) + 32'(bi) * 32'(W_RE)) >>> 14;
   end

   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < N; i++) begin
            ram_re[i] <= (i == 0) ? 16'sh0100 : 16'sh0000;
            ram_im[i] <= 16'sh0000;
         end
      end else if (sig.wr_en) begin
         ram_re[sig.wr_addr_a] <= p3[0];
         ram_im[sig.wr_addr_a] <= p3[1];
         ram_re[sig.wr_addr_b] <= p3[2];
         ram_im[sig.wr_addr_b] <= p3[3];
      end
      if (sig.rd_en) begin
         ar <= ram_re[sig.rd_addr_a];
         ai <= ram_im[sig.rd_addr_a];
         br <= ram_re[sig.rd_addr_b];
         bi <= ram_im[sig.rd_addr_b];
      end
      p1[0] <= ar + m_re[15:0];
      p1[1] <= ai + m_im[15:0];
      p1[2] <= ar - m_re[15:0];
      p1[3] <= ai - m_im[15:0];
      p2 <= p1;
      p3 <= p2;
   end

   task automatic check_outs_zero(input string nm);
      check($sformatf("%s busy", nm), int'(sig.busy), 0);
      check($sformatf("%s done", nm), int'(sig.done), 0);
      check($sformatf("%s stage", nm), int'(sig.stage), 0);
      check($sformatf("%s rd_en", nm), int'(sig.rd_en), 0);
      check($sformatf("%s rd_addr_a", nm), int'(sig.rd_addr_a), 0);
      check($sformatf("%s rd_addr_b", nm), int'(sig.rd_addr_b), 0);
      check($sformatf("%s tw_addr", nm), int'(sig.tw_addr), 0);
      check($sformatf("%s wr_en", nm), int'(sig.wr_en), 0);
      check($sformatf("%s wr_addr_a", nm), int'(sig.wr_addr_a), 0);
      check($sformatf("%s wr_addr_b", nm), int'(sig.wr_addr_b), 0);
   endtask

   // One full transform; extra_at>0 re-pulses start that many cycles after the accepted start
   task automatic do_run(input string nm, input int extra_at);
      int t0;
      bit seen;
      @(negedge clk); ram_load = 1'b1;
      @(negedge clk); ram_load = 1'b0;
      @(posedge clk); #1; clear_mon();
      @(negedge clk); sig.start = 1'b1; t0 = cyc;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (sig.done) begin
            seen = 1'b1;
            sig.start = 1'b1;
         end else begin
            sig.start = (extra_at > 0) && (cyc == t0 + extra_at);
         end
      end
      check($sformatf("%s done_seen", nm), int'(seen), 1);
      @(negedge clk); sig.start = 1'b0;
      repeat (6) @(negedge clk);

      check($sformatf("%s rd_count", nm), rd_cyc.size(), 12);
      check($sformatf("%s wr_count", nm), wr_cyc.size(), 12);
      for (int i = 0; i < 12 && i < rd_cyc.size(); i++) begin
         check($sformatf("%s rd%0d cyc", nm, i), rd_cyc[i] - t0, 1 + (i / 4) * 8 + (i % 4));
         check($sformatf("%s rd%0d stage", nm, i), rd_stg[i], i / 4);
         check($sformatf("%s rd%0d a", nm, i), rd_a[i], exp_a[i]);
         check($sformatf("%s rd%0d b", nm, i), rd_b[i], exp_b[i]);
         check($sformatf("%s rd%0d tw", nm, i), rd_tw[i], exp_tw[i]);
      end
      for (int i = 0; i < 12 && i < wr_cyc.size(); i++) begin
         check($sformatf("%s wr%0d cyc", nm, i), wr_cyc[i] - t0, 1 + D + (i / 4) * 8 + (i % 4));
         check($sformatf("%s wr%0d a", nm, i), wr_a[i], exp_a[i]);
         check($sformatf("%s wr%0d b", nm, i), wr_b[i], exp_b[i]);
      end
      check($sformatf("%s busy_cycles", nm), busy_cnt, 24);
      check($sformatf("%s done_pulses", nm), done_cnt, 1);
      check($sformatf("%s done_cyc", nm), done_cyc - t0, 25);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s bin%0d re", nm, i), int'(ram_re[i]), 256);
         check($sformatf("%s bin%0d im", nm, i), int'(ram_im[i]), 0);
      end
   endtask

   initial begin
      sig.start = 1'b0;
      #2 reset = 1'b1;
      #1 check_outs_zero("rst_init");
      @(negedge clk);
      @(negedge clk) reset = 1'b0;

      @(posedge clk); #1; clear_mon();
      repeat (10) @(negedge clk);
      check("idle busy", busy_cnt, 0);
      check("idle rd_en", rd_cyc.size(), 0);
      check("idle wr_en", wr_cyc.size(), 0);

      do_run("run0", 0);
      do_run("abuse", 10);

      @(negedge clk); sig.start = 1'b1;
      @(negedge clk); sig.start = 1'b0;
      for (int i = 0; i < 50 && sig.stage != 4'd1; i++) @(negedge clk);
      check("rst reach_stage1", int'(sig.stage), 1);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1 check_outs_zero("rst_mid");
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1; clear_mon();
      repeat (10) @(negedge clk);
      check("post_rst wr_en", wr_cyc.size(), 0);
      check("post_rst rd_en", rd_cyc.size(), 0);
      check("post_rst busy", busy_cnt, 0);

      do_run("after_rst", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
